// File: rtl/st_wbuf_if.sv
// Store write-buffer bus: pipeline store request channel, memory write
// channel and the busy indication, grouped for st_wbuf.
// master = pipeline/memory side driver, slave = the buffer itself.
interface st_wbuf_if;
   logic        st_valid;
   logic        st_ready;
   logic [63:0] st_addr;
   logic [63:0] st_data;
   logic [1:0]  st_size;
   logic        st_misalign;
   logic        mem_wvalid;
   logic        mem_wready;
   logic [63:0] mem_waddr;
   logic [63:0] mem_wdata;
   logic [7:0]  mem_wstrb;
   logic        busy;

   modport master (
      output st_valid, st_addr, st_data, st_size, mem_wready,
      input  st_ready, st_misalign, mem_wvalid, mem_waddr, mem_wdata,
             mem_wstrb, busy
   );

   modport slave (
      input  st_valid, st_addr, st_data, st_size, mem_wready,
      output st_ready, st_misalign, mem_wvalid, mem_waddr, mem_wdata,
             mem_wstrb, busy
   );
endinterface

// File: rtl/st_wbuf.sv
// st_wbuf: store write buffer. Turns pipeline stores into doubleword-aligned
// write beats (lane-shifted data + byte strobe), queues them in a DEPTH-entry
// FIFO and drains them to the data-memory write port over valid/ready.
// Optional feature macro: ST_FWD_EN adds ld_addr/ld_strb/ld_conflict so the
// load unit can stall only on an overlapping buffered store.
module st_wbuf #(
   parameter int DEPTH = 2,
   parameter int PTR_W = 1
) (
   input  logic        clock,
   input  logic        reset,
   st_wbuf_if.slave    bus
`ifdef ST_FWD_EN
   ,
   input  logic [63:0] ld_addr,
   input  logic [7:0]  ld_strb,
   output logic        ld_conflict
`endif
);

   typedef struct packed {
      logic [60:0] line;   // waddr[63:3]
      logic [63:0] data;   // lane-aligned data
      logic [7:0]  strb;   // byte strobe
   } entry_t;

   localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

   entry_t           mem [DEPTH];
   logic [DEPTH-1:0] vld;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;

   logic [7:0]  base_strb;
   logic [7:0]  new_strb;
   logic [63:0] new_data;
   logic        misalign;
   logic        full;
   logic        push;
   logic        pop;
   entry_t      head;

   // Size decode to the base strobe and alignment check of the incoming store.
   always_comb begin
      base_strb = 8'h01;
      misalign  = 1'b0;
      case (bus.st_size)
         2'b00: base_strb = 8'h01;
         2'b01: begin
            base_strb = 8'h03;
            misalign  = bus.st_addr[0];
         end
         2'b10: begin
            base_strb = 8'h0F;
            misalign  = (bus.st_addr[1:0] != 2'b00);
         end
         default: begin
            base_strb = 8'hFF;
            misalign  = (bus.st_addr[2:0] != 3'b000);
         end
      endcase
   end

   assign new_strb = base_strb << bus.st_addr[2:0];
   assign new_data = bus.st_data << {bus.st_addr[2:0], 3'b000};

   assign full  = (count == FULL_CNT);
   // Misaligned requests are consumed (ready unaffected) but never enqueued.
   assign push  = bus.st_valid && !full && !misalign;
   assign pop   = vld[rd_ptr] && bus.mem_wready;
   assign head  = mem[rd_ptr];

   // Inputs are ignored while reset is held, so the trap flag is gated too.
   assign bus.st_misalign = reset && bus.st_valid && misalign;
   assign bus.st_ready    = !full;
   assign bus.mem_wvalid  = vld[rd_ptr];
   assign bus.mem_waddr   = {head.line, 3'b000};
   assign bus.mem_wdata   = head.data;
   assign bus.mem_wstrb   = head.strb;
   assign bus.busy        = (count != '0);

   // FIFO storage, valid bits, pointers and occupancy count.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         vld    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         // push and pop never hit the same slot: push needs !full, pop needs
         // a valid head, and the pointers only coincide when full or empty.
         if (push) begin
            mem[wr_ptr] <= '{line: bus.st_addr[63:3], data: new_data, strb: new_strb};
            vld[wr_ptr] <= 1'b1;
            wr_ptr      <= PTR_W'(wr_ptr + 1'b1);
         end
         if (pop) begin
            vld[rd_ptr] <= 1'b0;
            rd_ptr      <= PTR_W'(rd_ptr + 1'b1);
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

`ifdef ST_FWD_EN
   logic unused_ld_lo;
   assign unused_ld_lo = ^ld_addr[2:0];

   // A load conflicts with any buffered beat on the same doubleword that
   // shares at least one byte lane.
   always_comb begin
      ld_conflict = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (vld[i] && (mem[i].line == ld_addr[63:3]) && ((mem[i].strb & ld_strb) != 8'h00))
            ld_conflict = 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_st_wbuf.sv
// Self-checking bench for st_wbuf: table of single-cycle vectors plus
// hand-written sequences for backpressure/full, reset mid-drain and the
// optional load-conflict compare.
module tb_st_wbuf;
   logic clock;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   st_wbuf_if bus_if ();

`ifdef ST_FWD_EN
   logic [63:0] ld_addr;
   logic [7:0]  ld_strb;
   logic        ld_conflict;
`endif

   st_wbuf #(.DEPTH(2), .PTR_W(1)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus_if.slave)
`ifdef ST_FWD_EN
      ,
      .ld_addr     (ld_addr),
      .ld_strb     (ld_strb),
      .ld_conflict (ld_conflict)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        v;
      logic [63:0] addr;
      logic [63:0] data;
      logic [1:0]  size;
      logic        wready;
      logic        mis;     // expected before the edge
      logic        rdy;     // expected before the edge
      logic        wv;      // expected after the edge
      logic [63:0] waddr;
      logic [63:0] wdata;
      logic [7:0]  wstrb;
      logic        busy;
   } vec_t;

   vec_t tbl [13];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic [63:0] a, input logic [63:0] d,
                        input logic [1:0] s, input logic wr);
      bus_if.st_valid   = v;
      bus_if.st_addr    = a;
      bus_if.st_data    = d;
      bus_if.st_size    = s;
      bus_if.mem_wready = wr;
   endtask

   task automatic chk_head(input string name, input logic [63:0] a, input logic [63:0] d,
                           input logic [7:0] s);
      chk({name, ".wvalid"}, {63'd0, bus_if.mem_wvalid}, 64'd1);
      chk({name, ".waddr"}, bus_if.mem_waddr, a);
      chk({name, ".wdata"}, bus_if.mem_wdata, d);
      chk({name, ".wstrb"}, {56'd0, bus_if.mem_wstrb}, {56'd0, s});
   endtask

   initial begin
      //          v     addr        data                    sz     wr    mis   rdy   wv    waddr       wdata                   wstrb  busy
      tbl[0]  = '{1'b1, 64'h1005, 64'hAB,                 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 64'h1000, 64'h0000_AB00_0000_0000, 8'h20, 1'b1};
      tbl[1]  = '{1'b0, 64'h0,    64'h0,                  2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0,    64'h0,                  8'h00, 1'b0};
      tbl[2]  = '{1'b1, 64'h2004, 64'hDEADBEEF,           2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 64'h2000, 64'hDEADBEEF_0000_0000, 8'hF0, 1'b1};
      tbl[3]  = '{1'b1, 64'h2002, 64'h1234,               2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 64'h2000, 64'h0000_0000_1234_0000, 8'h0C, 1'b1};
      tbl[4]  = '{1'b1, 64'h3004, 64'h55,                 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0,    64'h0,                  8'h00, 1'b0};
      tbl[5]  = '{1'b1, 64'h3000, 64'h1122334455667788,   2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 64'h3000, 64'h1122334455667788,   8'hFF, 1'b1};
      tbl[6]  = '{1'b0, 64'h0,    64'h0,                  2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0,    64'h0,                  8'h00, 1'b0};
      tbl[7]  = '{1'b1, 64'h4001, 64'h77,                 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0,    64'h0,                  8'h00, 1'b0};
      tbl[8]  = '{1'b1, 64'h4006, 64'h88,                 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0,    64'h0,                  8'h00, 1'b0};
      tbl[9]  = '{1'b1, 64'h4008, 64'hCAFEF00D,           2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 64'h4008, 64'hCAFEF00D,           8'h0F, 1'b1};
      tbl[10] = '{1'b0, 64'h0,    64'h0,                  2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0,    64'h0,                  8'h00, 1'b0};
      tbl[11] = '{1'b1, 64'h4006, 64'hBEEF,               2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 64'h4000, 64'hBEEF_0000_0000_0000, 8'hC0, 1'b1};
      tbl[12] = '{1'b0, 64'h7,    64'h0,                  2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0,    64'h0,                  8'h00, 1'b0};

`ifdef ST_FWD_EN
      ld_addr = 64'h0;
      ld_strb = 8'h00;
`endif
      // Reset state, with a misaligned request present to show it is ignored.
      reset = 1'b0;
      drive(1'b1, 64'h3, 64'h0, 2'b11, 1'b0);
      #2;
      chk("rst.wvalid",   {63'd0, bus_if.mem_wvalid}, 64'd0);
      chk("rst.busy",     {63'd0, bus_if.busy}, 64'd0);
      chk("rst.misalign", {63'd0, bus_if.st_misalign}, 64'd0);
      chk("rst.waddr",    bus_if.mem_waddr, 64'd0);
      chk("rst.wdata",    bus_if.mem_wdata, 64'd0);
      chk("rst.wstrb",    {56'd0, bus_if.mem_wstrb}, 64'd0);
      drive(1'b0, 64'h0, 64'h0, 2'b00, 1'b0);
      repeat (2) cyc();
      reset = 1'b1;
      #1;
      chk("rst.ready", {63'd0, bus_if.st_ready}, 64'd1);
      cyc();

      // Table-driven single-cycle vectors.
      for (int i = 0; i < 13; i++) begin
         drive(tbl[i].v, tbl[i].addr, tbl[i].data, tbl[i].size, tbl[i].wready);
         #1;
         chk($sformatf("vec%0d.misalign", i), {63'd0, bus_if.st_misalign}, {63'd0, tbl[i].mis});
         chk($sformatf("vec%0d.ready", i),    {63'd0, bus_if.st_ready},    {63'd0, tbl[i].rdy});
         cyc();
         chk($sformatf("vec%0d.wvalid", i), {63'd0, bus_if.mem_wvalid}, {63'd0, tbl[i].wv});
         chk($sformatf("vec%0d.busy", i),   {63'd0, bus_if.busy},       {63'd0, tbl[i].busy});
         if (tbl[i].wv) begin
            chk($sformatf("vec%0d.waddr", i), bus_if.mem_waddr, tbl[i].waddr);
            chk($sformatf("vec%0d.wdata", i), bus_if.mem_wdata, tbl[i].wdata);
            chk($sformatf("vec%0d.wstrb", i), {56'd0, bus_if.mem_wstrb}, {56'd0, tbl[i].wstrb});
         end
      end

      // Backpressure: fill, stall a third store, single pop, then drain in order.
      drive(1'b1, 64'h5000, 64'h11, 2'b00, 1'b0);
      cyc();
      drive(1'b1, 64'h5001, 64'h22, 2'b00, 1'b0);
      cyc();
      chk("full.ready", {63'd0, bus_if.st_ready}, 64'd0);
      chk("full.busy",  {63'd0, bus_if.busy}, 64'd1);
      chk_head("full.head", 64'h5000, 64'h11, 8'h01);
      drive(1'b1, 64'h5002, 64'h33, 2'b00, 1'b0);
      for (int k = 0; k < 2; k++) begin
         cyc();
         chk_head($sformatf("stall%0d", k), 64'h5000, 64'h11, 8'h01);
         chk($sformatf("stall%0d.ready", k), {63'd0, bus_if.st_ready}, 64'd0);
      end
      bus_if.mem_wready = 1'b1;
      #1;
      chk("popcyc.ready", {63'd0, bus_if.st_ready}, 64'd0);
      cyc();
      chk_head("afterpop", 64'h5000, 64'h2200, 8'h02);
      chk("afterpop.ready", {63'd0, bus_if.st_ready}, 64'd1);
      bus_if.mem_wready = 1'b0;
      cyc();
      chk("s3push.ready", {63'd0, bus_if.st_ready}, 64'd0);
      chk_head("s3push.head", 64'h5000, 64'h2200, 8'h02);
      drive(1'b0, 64'h0, 64'h0, 2'b00, 1'b1);
      cyc();
      chk_head("drain.s3", 64'h5000, 64'h33_0000, 8'h04);
      cyc();
      chk("drain.wvalid", {63'd0, bus_if.mem_wvalid}, 64'd0);
      chk("drain.busy",   {63'd0, bus_if.busy}, 64'd0);

`ifdef ST_FWD_EN
      // Load-conflict compare against a buffered word.
      drive(1'b1, 64'h4000, 64'h01020304, 2'b10, 1'b0);
      cyc();
      drive(1'b0, 64'h0, 64'h0, 2'b00, 1'b0);
      ld_addr = 64'h4004;
      ld_strb = 8'hF0;
      #1;
      chk("fwd.nolap", {63'd0, ld_conflict}, 64'd0);
      ld_addr = 64'h4002;
      ld_strb = 8'h0C;
      #1;
      chk("fwd.lap", {63'd0, ld_conflict}, 64'd1);
      ld_addr = 64'h5002;
      #1;
      chk("fwd.otherline", {63'd0, ld_conflict}, 64'd0);
      bus_if.mem_wready = 1'b1;
      cyc();
      ld_addr = 64'h4002;
      #1;
      chk("fwd.drained", {63'd0, ld_conflict}, 64'd0);
`endif

      // Reset mid-drain discards both entries.
      drive(1'b1, 64'h6000, 64'hA1, 2'b00, 1'b0);
      cyc();
      drive(1'b1, 64'h6001, 64'hA2, 2'b00, 1'b0);
      cyc();
      chk("prerst.busy", {63'd0, bus_if.busy}, 64'd1);
      drive(1'b1, 64'h6003, 64'h0, 2'b11, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      chk("midrst.wvalid",   {63'd0, bus_if.mem_wvalid}, 64'd0);
      chk("midrst.busy",     {63'd0, bus_if.busy}, 64'd0);
      chk("midrst.misalign", {63'd0, bus_if.st_misalign}, 64'd0);
      chk("midrst.waddr",    bus_if.mem_waddr, 64'd0);
      chk("midrst.ready",    {63'd0, bus_if.st_ready}, 64'd1);
      drive(1'b0, 64'h0, 64'h0, 2'b00, 1'b1);
      cyc();
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk($sformatf("postrst%0d.wvalid", k), {63'd0, bus_if.mem_wvalid}, 64'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
